// File: rtl/t05_translation_pkg.sv
// Shared types and defaults for the translation packer: FSM state encoding,
// default terminator/enable constants and a small width helper.
package t05_translation_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_REQ_CHAR  = 3'd2,
    S_WAIT_CODE = 3'd3,
    S_EMIT      = 3'd4,
    S_FLUSH     = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  localparam logic [7:0] DEF_EOF_CHAR = 8'h1A;
  localparam logic [3:0] DEF_EN_STATE = 4'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/t05_bit_packer.sv
// MSB-first bit accumulator feeding an OUT_W-bit word register with a
// valid/ready handshake; flush pads a partial word with zeros.
module t05_bit_packer #(
  parameter int OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             flush_i,
  input  logic             out_ready_i,
  output logic             bit_ready_o,
  output logic             out_valid_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             empty_o
);

  localparam int CW = $clog2(OUT_W + 1);

  logic [OUT_W-1:0] acc_q, acc_d, data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             acc_full_s, slot_free_s, move_s, shift_s;

  assign acc_full_s  = (cnt_q == CW'(OUT_W));
  assign slot_free_s = !valid_q || out_ready_i;
  assign move_s      = (acc_full_s || (flush_i && (cnt_q != {CW{1'b0}}))) && slot_free_s;
  assign bit_ready_o = !acc_full_s || slot_free_s;
  assign shift_s     = bit_valid_i && bit_ready_o;

  // Next-state: drain/move a word, then shift in a bit; a completed word goes straight out when the slot is free
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (en_i) begin
      if (valid_q && out_ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      if (move_s) begin
        data_d  = acc_q;
        valid_d = 1'b1;
        acc_d   = {OUT_W{1'b0}};
        cnt_d   = {CW{1'b0}};
      end else begin
        data_d  = data_q;
      end
      if (shift_s) begin
        acc_d = acc_d | (OUT_W'(bit_i) << (CW'(OUT_W - 1) - cnt_d));
        cnt_d = cnt_d + CW'(1);
        if ((cnt_d == CW'(OUT_W)) && !valid_d) begin
          data_d  = acc_d;
          valid_d = 1'b1;
          acc_d   = {OUT_W{1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_d;
        end
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= {OUT_W{1'b0}};
      cnt_q   <= {CW{1'b0}};
      data_q  <= {OUT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign empty_o     = (cnt_q == {CW{1'b0}}) && !valid_q;

endmodule

// File: rtl/t05_translation_packer.sv
// Translation stage: emits the character-count header, then each character's
// codeword MSB-first, packed into OUT_W-bit words by t05_bit_packer.
module t05_translation_packer
  import t05_translation_pkg::*;
#(
  parameter int                CNT_W    = 32,
  parameter int                CODE_MAX = 128,
  parameter int                LEN_W    = $clog2(CODE_MAX + 1),
  parameter int                CHAR_W   = 8,
  parameter int                OUT_W    = 8,
  parameter logic [CHAR_W-1:0] EOF_CHAR = CHAR_W'(DEF_EOF_CHAR),
  parameter logic [3:0]        EN_STATE = DEF_EN_STATE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          en_state_i,
  input  logic [CNT_W-1:0]    tot_char_i,
  input  logic                char_valid_i,
  input  logic [CHAR_W-1:0]   char_in_i,
  output logic                char_ready_o,
  output logic                code_req_o,
  output logic [CHAR_W-1:0]   code_char_o,
  input  logic                code_valid_i,
  input  logic [CODE_MAX-1:0] code_path_i,
  input  logic [LEN_W-1:0]    code_len_i,
  output logic                out_valid_o,
  output logic [OUT_W-1:0]    out_data_o,
  input  logic                out_ready_i,
  output logic                err_o,
  output logic                fin_state_o
);

  localparam int BL_W = max_int(LEN_W, $clog2(CNT_W + 1));

  state_e              state_q;
  logic [CNT_W-1:0]    tot_q, hdr_q, consumed_q;
  logic [CODE_MAX-1:0] path_q;
  logic [BL_W-1:0]     left_q;
  logic                char_ready_q, code_req_q, err_q, fin_q;
  logic [CHAR_W-1:0]   code_char_q;

  logic             en_s, bit_valid_s, bit_s, bit_ready_s, flush_s, pk_empty_s;
  logic             last_bit_s, last_char_s, len_bad_s;
  logic [CNT_W-1:0] consumed_inc_s;

  assign en_s           = (en_state_i == EN_STATE);
  assign bit_valid_s    = en_s && ((state_q == S_HDR) || (state_q == S_EMIT));
  assign bit_s          = (state_q == S_HDR) ? hdr_q[CNT_W-1] : path_q[CODE_MAX-1];
  assign flush_s        = (state_q == S_FLUSH);
  assign last_bit_s     = (left_q == BL_W'(1));
  assign consumed_inc_s = consumed_q + CNT_W'(1);
  assign last_char_s    = (consumed_inc_s == tot_q);
  assign len_bad_s      = (code_len_i == {LEN_W{1'b0}}) || (code_len_i > LEN_W'(CODE_MAX));

  t05_bit_packer #(.OUT_W(OUT_W)) u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_s),
    .bit_i       (bit_s),
    .bit_valid_i (bit_valid_s),
    .flush_i     (flush_s),
    .out_ready_i (out_ready_i),
    .bit_ready_o (bit_ready_s),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .empty_o     (pk_empty_s)
  );

  // Sequencing FSM; codewords are left-aligned on load so both shift paths take the MSB
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tot_q        <= {CNT_W{1'b0}};
      hdr_q        <= {CNT_W{1'b0}};
      consumed_q   <= {CNT_W{1'b0}};
      path_q       <= {CODE_MAX{1'b0}};
      left_q       <= {BL_W{1'b0}};
      char_ready_q <= 1'b0;
      code_req_q   <= 1'b0;
      code_char_q  <= {CHAR_W{1'b0}};
      err_q        <= 1'b0;
      fin_q        <= 1'b0;
    end else if (en_s) begin
      code_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tot_q      <= tot_char_i;
          hdr_q      <= tot_char_i;
          consumed_q <= {CNT_W{1'b0}};
          left_q     <= BL_W'(CNT_W);
          fin_q      <= 1'b0;
          state_q    <= S_HDR;
        end
        S_HDR: begin
          if (bit_ready_s) begin
            hdr_q  <= {hdr_q[CNT_W-2:0], 1'b0};
            left_q <= left_q - BL_W'(1);
            if (last_bit_s) begin
              if (tot_q == {CNT_W{1'b0}}) begin
                state_q <= S_FLUSH;
              end else begin
                state_q      <= S_REQ_CHAR;
                char_ready_q <= 1'b1;
              end
            end
          end
        end
        S_REQ_CHAR: begin
          if (char_valid_i && char_ready_q) begin
            char_ready_q <= 1'b0;
            if (char_in_i == EOF_CHAR) begin
              state_q <= S_FLUSH;
            end else begin
              code_char_q <= char_in_i;
              code_req_q  <= 1'b1;
              state_q     <= S_WAIT_CODE;
            end
          end
        end
        S_WAIT_CODE: begin
          if (code_valid_i) begin
            if (len_bad_s) begin
              err_q      <= 1'b1;
              consumed_q <= consumed_inc_s;
              if (last_char_s) begin
                state_q <= S_FLUSH;
              end else begin
                state_q      <= S_REQ_CHAR;
                char_ready_q <= 1'b1;
              end
            end else begin
              path_q  <= code_path_i << (LEN_W'(CODE_MAX) - code_len_i);
              left_q  <= BL_W'(code_len_i);
              state_q <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (bit_ready_s) begin
            path_q <= {path_q[CODE_MAX-2:0], 1'b0};
            left_q <= left_q - BL_W'(1);
            if (last_bit_s) begin
              consumed_q <= consumed_inc_s;
              if (last_char_s) begin
                state_q <= S_FLUSH;
              end else begin
                state_q      <= S_REQ_CHAR;
                char_ready_q <= 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          if (pk_empty_s) begin
            state_q <= S_DONE;
            fin_q   <= 1'b1;
          end
        end
        S_DONE: begin
          fin_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end else if (state_q == S_DONE) begin
      state_q <= S_IDLE;
      fin_q   <= 1'b0;
    end
  end

  assign char_ready_o = char_ready_q;
  assign code_req_o   = code_req_q;
  assign code_char_o  = code_char_q;
  assign err_o        = err_q;
  assign fin_state_o  = fin_q;

endmodule

// File: tb/tb_t05_translation_packer.sv
// Directed bench for t05_translation_packer: header timing, encoding, EOF pad,
// backpressure, gating, bad code length and mid-header reset.
module tb_t05_translation_packer;

  localparam int CNT_W = 32, CODE_MAX = 128, LEN_W = 8, CHAR_W = 8, OUT_W = 8;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [3:0]          en_state_i = 4'd5;
  logic [CNT_W-1:0]    tot_char_i = 32'd0;
  logic                char_valid_i = 1'b0;
  logic [CHAR_W-1:0]   char_in_i = 8'h00;
  logic                char_ready_o;
  logic                code_req_o;
  logic [CHAR_W-1:0]   code_char_o;
  logic                code_valid_i = 1'b0;
  logic [CODE_MAX-1:0] code_path_i = {CODE_MAX{1'b0}};
  logic [LEN_W-1:0]    code_len_i = 8'd0;
  logic                out_valid_o;
  logic [OUT_W-1:0]    out_data_o;
  logic                out_ready_i = 1'b1;
  logic                err_o;
  logic                fin_state_o;

  t05_translation_packer dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_state_i(en_state_i), .tot_char_i(tot_char_i),
    .char_valid_i(char_valid_i), .char_in_i(char_in_i), .char_ready_o(char_ready_o),
    .code_req_o(code_req_o), .code_char_o(code_char_o), .code_valid_i(code_valid_i),
    .code_path_i(code_path_i), .code_len_i(code_len_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_ready_i(out_ready_i), .err_o(err_o),
    .fin_state_o(fin_state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_mis = 0;
  int cyc = 0, start_cyc = 0;
  logic [7:0] words[$];
  int         wcyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] chars[$];
  int  cidx = 0;
  bit  take_pending = 1'b0;
  int  nreq = 0, stab_err = 0, frz_err = 0, gated_n = 0, hold_n = 0;
  bit  prev_hold = 1'b0, prev_gated = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [20:0] prev_frz = 21'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Character source: advances after each accepted handshake
  always @(posedge clk_i) begin
    #1;
    if (take_pending) begin
      cidx++;
      take_pending = 1'b0;
    end
    char_valid_i = (cidx < chars.size());
    char_in_i    = (cidx < chars.size()) ? chars[cidx] : 8'h00;
  end

  // Codebook: answers a lookup in the cycle after the request pulse rises
  always @(posedge clk_i) begin
    #1;
    code_valid_i = 1'b0;
    code_path_i  = {CODE_MAX{1'b0}};
    code_len_i   = 8'd0;
    if (code_req_o) begin
      code_valid_i = 1'b1;
      case (code_char_o)
        8'h61:   begin code_path_i = 128'b101;           code_len_i = 8'd3;   end
        8'h62:   begin code_path_i = 128'b11001;         code_len_i = 8'd5;   end
        8'h64:   begin code_path_i = {16{8'hA5}};        code_len_i = 8'd128; end
        default: begin code_path_i = 128'h5;             code_len_i = 8'd0;   end
      endcase
    end
  end

  // Monitor: word capture, lookup count, stability and freeze checks
  always @(negedge clk_i) begin
    bit en_ok;
    bit cur_gated;
    logic [20:0] frz;
    en_ok = (en_state_i == 4'd5) && !rst_i;
    if (out_valid_o && out_ready_i && en_ok) begin
      words.push_back(out_data_o);
      wcyc.push_back(cyc);
    end
    if (code_req_o) nreq++;
    if (char_valid_i && char_ready_o && en_ok) take_pending = 1'b1;
    if (prev_hold && (!out_valid_o || out_data_o != prev_data)) stab_err++;
    prev_hold = out_valid_o && (!out_ready_i || !en_ok) && !rst_i;
    if (prev_hold) hold_n++;
    prev_data = out_data_o;
    frz = {char_ready_o, code_req_o, code_char_o, out_valid_o, out_data_o, err_o, fin_state_o};
    if (prev_gated && frz != prev_frz) frz_err++;
    cur_gated = (en_state_i != 4'd5) && !rst_i;
    if (cur_gated) gated_n++;
    prev_gated = cur_gated;
    prev_frz   = frz;
  end

  task automatic check_zero(input string tag);
    check_eq(tag, {11'd0, char_ready_o, code_req_o, code_char_o, out_valid_o,
                   out_data_o, err_o, fin_state_o}, 32'd0);
  endtask

  task automatic start_run(input logic [31:0] tot);
    @(posedge clk_i); #1;
    rst_i = 1'b1; en_state_i = 4'd5; out_ready_i = 1'b1; tot_char_i = tot;
    @(posedge clk_i); #1;
    words.delete(); wcyc.delete(); exp_q.delete();
    cidx = 0; take_pending = 1'b0;
    nreq = 0; stab_err = 0; frz_err = 0; gated_n = 0; hold_n = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic exp_hdr(input logic [31:0] tot);
    exp_q.push_back(tot[31:24]); exp_q.push_back(tot[23:16]);
    exp_q.push_back(tot[15:8]);  exp_q.push_back(tot[7:0]);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < start_cyc + n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_fin(input string tag);
    int n;
    n = 0;
    while (!fin_state_o && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    check_eq(tag, {31'd0, fin_state_o}, 32'd1);
  endtask

  task automatic check_words(input string tag);
    check_eq($sformatf("%s_count", tag), words.size(), exp_q.size());
    foreach (exp_q[i])
      check_eq($sformatf("%s_w%0d", tag, i),
               (i < words.size()) ? 32'(words[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_zero("rst_init");

    // Header only: EOF right after the header
    chars.delete(); chars.push_back(8'h1A);
    start_run(32'h0000_0003);
    exp_hdr(32'h0000_0003);
    wait_fin("hdr_fin");
    check_words("hdr");
    check_eq("hdr_lat", (wcyc.size() > 0) ? wcyc[0] - start_cyc : -1, 32'd9);
    check_eq("hdr_span", (wcyc.size() > 3) ? wcyc[3] - wcyc[0] : -1, 32'd24);

    // Two characters fill exactly one word, no pad
    chars.delete(); chars.push_back(8'h61); chars.push_back(8'h62);
    start_run(32'd2);
    exp_hdr(32'd2); exp_q.push_back(8'hB9);
    wait_fin("enc_fin");
    check_words("enc");
    check_eq("enc_req", nreq, 32'd2);

    // EOF before count reached: padded word, EOF not looked up
    chars.delete(); chars.push_back(8'h61); chars.push_back(8'h1A);
    start_run(32'd5);
    exp_hdr(32'd5); exp_q.push_back(8'hA0);
    wait_fin("eof_fin");
    check_words("eof");
    check_eq("eof_req", nreq, 32'd1);
    check_eq("eof_err", {31'd0, err_o}, 32'd0);

    // Full-length codeword under 20 cycles of backpressure
    chars.delete(); chars.push_back(8'h64);
    start_run(32'd1);
    exp_hdr(32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hA5);
    wait_cyc(60);
    out_ready_i = 1'b0;
    wait_cyc(80);
    out_ready_i = 1'b1;
    wait_fin("bp_fin");
    check_words("bp");
    check_eq("bp_stable", stab_err, 32'd0);
    check_eq("bp_held", {31'd0, hold_n >= 12}, 32'd1);

    // Bad length skipped, enable dropped mid-emit
    chars.delete(); chars.push_back(8'h63); chars.push_back(8'h64); chars.push_back(8'h61);
    start_run(32'd3);
    exp_hdr(32'd3);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA0);
    wait_cyc(70);
    en_state_i = 4'd2;
    wait_cyc(82);
    en_state_i = 4'd5;
    wait_fin("gate_fin");
    check_words("gate");
    check_eq("gate_err", {31'd0, err_o}, 32'd1);
    check_eq("gate_frozen", frz_err, 32'd0);
    check_eq("gate_seen", {31'd0, gated_n >= 10}, 32'd1);
    check_eq("gate_stable", stab_err, 32'd0);
    check_eq("gate_req", nreq, 32'd3);

    // Reset in the middle of the header, then a clean rerun
    chars.delete(); chars.push_back(8'h1A);
    start_run(32'h0000_0003);
    wait_cyc(12);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero("rst_mid");
    words.delete(); wcyc.delete(); cidx = 0; take_pending = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    start_cyc = cyc;
    exp_q.delete(); exp_hdr(32'h0000_0003);
    wait_fin("rerun_fin");
    check_words("rerun");
    check_eq("rerun_lat", (wcyc.size() > 0) ? wcyc[0] - start_cyc : -1, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
